mem_test_ctrl: RTL and testbench
================================

MEM_TEST_CTRL -- requirements
Module: mem_test_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, Avalon-MM word address width.
REQ-002 Parameter DATA_W, default 32, Avalon-MM data width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  start a test when idle; ignored while busy_o=1.
REQ-007 start_addr_i  input  ADDR_W  first address of the test range.
REQ-008 end_addr_i  input  ADDR_W  last address of the test range, inclusive.
REQ-009 pattern_i  input  DATA_W  base data pattern.
REQ-010 pattern_sel_i  input  1  0: data=pattern; 1: data=pattern XOR zero-extended address.
REQ-011 busy_o  output  1  test in progress.
REQ-012 done_o  output  1  one-cycle pulse at test end.
REQ-013 err_o  output  1  sticky mismatch flag; cleared on an accepted start.
REQ-014 err_cnt_o  output  8  mismatch count, saturating at 255.
REQ-015 err_addr_o  output  ADDR_W  address of the first mismatch of the current test.
REQ-016 amm_read_o, amm_write_o  output  1 each  Avalon-MM read/write requests.
REQ-017 amm_address_o  output  ADDR_W  request address.
REQ-018 amm_writedata_o  output  DATA_W  write data.
REQ-019 amm_readdata_i  input  DATA_W  read data.
REQ-020 amm_waitrequest_i  input  1  slave stall; a request is accepted in a cycle with the request asserted and waitrequest=0.
REQ-021 amm_readdatavalid_i  input  1  readdata valid strobe.

Function
REQ-022 FSM states: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
REQ-023 IDLE, start_i=1: latch start/end address, pattern and pattern_sel; clear err_o, err_cnt_o, err_addr_o; addr<=start_addr; go to WRITE.
REQ-024 WRITE: amm_write_o=1 with address=addr and writedata=expected(addr); hold all three stable until accepted.
REQ-025 WRITE accept: if addr==end, addr<=start and go to READ_REQ; else addr<=addr+1 mod 2^ADDR_W.
REQ-026 READ_REQ: amm_read_o=1 with address=addr; hold until accepted, then go to READ_WAIT.
REQ-027 READ_WAIT: no request asserted; wait for amm_readdatavalid_i=1 with no timeout.
REQ-028 On readdatavalid in READ_WAIT: compare readdata with expected(addr); if addr==end go to DONE, else addr<=addr+1 and go to READ_REQ.
REQ-029 On mismatch: err_o<=1; err_cnt_o increments, holding at 255; err_addr_o<=addr only if err_o was 0.
REQ-030 At most one read outstanding; readdatavalid outside READ_WAIT SHALL be ignored.
REQ-031 DONE: done_o=1 for exactly one cycle; next state IDLE.
REQ-032 busy_o=1 in every state except IDLE.
REQ-033 amm_read_o and amm_write_o SHALL never be 1 in the same cycle.
REQ-034 start_addr==end_addr: test exactly one word (1 write, 1 read).
REQ-035 start_addr>end_addr: address wraps from 2^ADDR_W-1 to 0; test covers (end-start+1) mod 2^ADDR_W words.
REQ-036 err_o, err_cnt_o and err_addr_o SHALL hold their values after DONE until the next accepted start.
REQ-037 expected(a)=pattern when pattern_sel=0; pattern XOR {zeros, a} when pattern_sel=1.

Reset
REQ-038 rst_i=1 SHALL force IDLE and set all outputs to 0 on the next edge, including mid-transaction; any outstanding read response is discarded.
REQ-039 After reset release, no request is issued until start_i.

Verification
REQ-040 Range 2..5, pattern 0xA5A5A5A5, sel=0, zero-latency slave -> writes to 2,3,4,5, then 4 reads; done_o pulses once; err_o=0, err_cnt_o=0.
REQ-041 sel=1, pattern 0xFFFF0000, range 0..3, slave returns 0 at address 2 -> err_o=1, err_cnt_o=1, err_addr_o=2.
REQ-042 amm_waitrequest_i held high 3 cycles on every request -> address, data and request stable while stalled; no address skipped.
REQ-043 Range 14..1 with ADDR_W=4 -> addresses 14,15,0,1 written then read in that order.
REQ-044 All 16 reads corrupted, range 0..15, then second start -> err_cnt_o=16 first run; cleared to 0 when the second start is accepted.
REQ-045 rst_i asserted in READ_WAIT; late readdatavalid after release -> busy_o=0, no error counted; start_i during busy ignored.

Source files
------------

// File: rtl/mem_test_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_test_ctrl_if
// Brief    : Avalon-MM master/slave bundle used by the memory test controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_test_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output read, write, address, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/mem_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_test_ctrl
// Brief    : Write-then-readback memory tester driving an Avalon-MM slave.
// Revision : 1.0 - initial release
// ============================================================================
module mem_test_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              start_i,
    input  wire logic [ADDR_W-1:0] start_addr_i,
    input  wire logic [ADDR_W-1:0] end_addr_i,
    input  wire logic [DATA_W-1:0] pattern_i,
    input  wire logic              pattern_sel_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [7:0]             err_cnt_o,
    output logic [ADDR_W-1:0]      err_addr_o,
    mem_test_ctrl_if.master        amm
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WRITE     = 3'd1;
    localparam logic [2:0] c_ST_READ_REQ  = 3'd2;
    localparam logic [2:0] c_ST_READ_WAIT = 3'd3;
    localparam logic [2:0] c_ST_DONE      = 3'd4;
    localparam logic [7:0] c_CNT_MAX      = 8'hFF;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start_addr;
    logic [ADDR_W-1:0] r_end_addr;
    logic [DATA_W-1:0] r_pattern;
    logic              r_pattern_sel;
    logic              r_err;
    logic [7:0]        r_err_cnt;
    logic [ADDR_W-1:0] r_err_addr;

    logic [DATA_W-1:0] w_expected;
    logic              w_at_end;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_rsp;
    logic              w_mismatch;

    assign w_expected  = r_pattern_sel ? (r_pattern ^ DATA_W'(r_addr)) : r_pattern;
    assign w_at_end    = (r_addr == r_end_addr);
    assign w_wr_accept = (r_state == c_ST_WRITE)     && !amm.waitrequest;
    assign w_rd_accept = (r_state == c_ST_READ_REQ)  && !amm.waitrequest;
    // Responses arriving in any other state (e.g. one orphaned by reset) are dropped.
    assign w_rsp       = (r_state == c_ST_READ_WAIT) && amm.readdatavalid;
    assign w_mismatch  = w_rsp && (amm.readdata != w_expected);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:      if (start_i)     w_next_state = c_ST_WRITE;
            c_ST_WRITE:     if (w_wr_accept && w_at_end) w_next_state = c_ST_READ_REQ;
            c_ST_READ_REQ:  if (w_rd_accept) w_next_state = c_ST_READ_WAIT;
            c_ST_READ_WAIT: if (w_rsp)       w_next_state = w_at_end ? c_ST_DONE : c_ST_READ_REQ;
            c_ST_DONE:      w_next_state = c_ST_IDLE;
            default:        w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (r_state != c_ST_IDLE);
        done_o        = 1'b0;
        amm.read      = 1'b0;
        amm.write     = 1'b0;
        amm.address   = '0;
        amm.writedata = '0;
        case (r_state)
            c_ST_WRITE: begin
                amm.write     = 1'b1;
                amm.address   = r_addr;
                amm.writedata = w_expected;
            end
            c_ST_READ_REQ: begin
                amm.read    = 1'b1;
                amm.address = r_addr;
            end
            c_ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr        <= '0;
            r_start_addr  <= '0;
            r_end_addr    <= '0;
            r_pattern     <= '0;
            r_pattern_sel <= 1'b0;
            r_err         <= 1'b0;
            r_err_cnt     <= '0;
            r_err_addr    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_start_addr  <= start_addr_i;
                        r_end_addr    <= end_addr_i;
                        r_pattern     <= pattern_i;
                        r_pattern_sel <= pattern_sel_i;
                        r_addr        <= start_addr_i;
                        r_err         <= 1'b0;
                        r_err_cnt     <= '0;
                        r_err_addr    <= '0;
                    end
                end
                c_ST_WRITE: begin
                    // Wrap back to the first address so the read pass replays the same range.
                    if (w_wr_accept) begin
                        r_addr <= w_at_end ? r_start_addr : r_addr + ADDR_W'(1);
                    end
                end
                c_ST_READ_WAIT: begin
                    if (w_rsp) begin
                        if (!w_at_end) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                        if (w_mismatch) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != c_CNT_MAX) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                            if (!r_err) begin
                                r_err_addr <= r_addr;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_o      = r_err;
    assign err_cnt_o  = r_err_cnt;
    assign err_addr_o = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_test_ctrl
// Brief    : Directed bench with an Avalon-MM slave model and request scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_test_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int N      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [DATA_W-1:0] pattern = '0;
    logic              pattern_sel = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        err_cnt;
    logic [ADDR_W-1:0] err_addr;

    mem_test_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) amm ();

    mem_test_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .start_addr_i  (start_addr),
        .end_addr_i    (end_addr),
        .pattern_i     (pattern),
        .pattern_sel_i (pattern_sel),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .err_cnt_o     (err_cnt),
        .err_addr_o    (err_addr),
        .amm           (amm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    txn_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [DATA_W-1:0] mem [N];
    bit                zero_at [N];
    bit                corrupt_all   = 1'b0;
    int                stall_cycles  = 0;
    int                rd_lat        = 0;
    int                wait_ctr      = 0;
    bit                pending       = 1'b0;
    logic [ADDR_W-1:0] pend_addr     = '0;
    int                pend_delay    = 0;
    bit                read_accepted = 1'b0;
    int                done_count    = 0;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              hold_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] p, input logic sel,
                                                   input logic [ADDR_W-1:0] a);
        return sel ? (p ^ DATA_W'(a)) : p;
    endfunction

    function automatic logic [DATA_W-1:0] slave_ret(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] stored);
        if (zero_at[a]) return '0;
        return corrupt_all ? (stored ^ 32'h1) : stored;
    endfunction

    // Slave model and request monitor: decisions made mid-cycle, effective at the next rising edge.
    always @(negedge clk) begin
        txn_t e;
        if (done === 1'b1) done_count++;
        amm.readdatavalid = 1'b0;
        if (pending) begin
            if (pend_delay == 0) begin
                amm.readdatavalid = 1'b1;
                amm.readdata      = slave_ret(pend_addr, mem[pend_addr]);
                pending           = 1'b0;
            end else begin
                pend_delay--;
            end
        end
        amm.waitrequest = 1'b0;
        if (!rst && (amm.read === 1'b1 || amm.write === 1'b1)) begin
            check("rw_exclusive", 32'(amm.read & amm.write), 32'd0);
            if (wait_ctr == 0) begin
                hold_addr = amm.address;
                hold_data = amm.writedata;
                hold_wr   = amm.write;
            end else begin
                check("stall_kind", 32'(amm.write), 32'(hold_wr));
                check("stall_addr", 32'(amm.address), 32'(hold_addr));
                if (hold_wr) check("stall_data", amm.writedata, hold_data);
            end
            if (wait_ctr < stall_cycles) begin
                amm.waitrequest = 1'b1;
                wait_ctr++;
            end else begin
                wait_ctr = 0;
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("req_kind", 32'(amm.write), 32'(e.wr));
                    check("req_addr", 32'(amm.address), 32'(e.addr));
                    if (e.wr) check("wr_data", amm.writedata, e.data);
                end
                if (amm.write) begin
                    mem[amm.address] = amm.writedata;
                end else begin
                    pending       = 1'b1;
                    pend_addr     = amm.address;
                    pend_delay    = rd_lat;
                    read_accepted = 1'b1;
                end
            end
        end else begin
            wait_ctr = 0;
        end
    end

    task automatic push_expected(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                                 input logic [DATA_W-1:0] p, input logic sel,
                                 output int exp_cnt, output logic [ADDR_W-1:0] exp_first);
        logic [ADDR_W-1:0] diff;
        logic [ADDR_W-1:0] a;
        int n;
        diff = e - s;
        n = int'(diff) + 1;
        exp_cnt = 0;
        exp_first = '0;
        for (int i = 0; i < n; i++) begin
            a = s + ADDR_W'(i);
            sb.push_back('{wr: 1'b1, addr: a, data: exp_data(p, sel, a)});
        end
        for (int i = 0; i < n; i++) begin
            a = s + ADDR_W'(i);
            sb.push_back('{wr: 1'b0, addr: a, data: '0});
            if (slave_ret(a, exp_data(p, sel, a)) != exp_data(p, sel, a)) begin
                if (exp_cnt == 0) exp_first = a;
                exp_cnt++;
            end
        end
    endtask

    task automatic drive_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                               input logic [DATA_W-1:0] p, input logic sel);
        @(posedge clk); #1;
        start_addr = s; end_addr = e; pattern = p; pattern_sel = sel; start = 1'b1;
        done_count = 0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
        check("cnt_cleared", 32'(err_cnt), 32'd0);
        check("eaddr_cleared", 32'(err_addr), 32'd0);
    endtask

    task automatic run_test(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                            input logic [DATA_W-1:0] p, input logic sel,
                            input int stall, input int lat, input bit poke);
        int exp_cnt;
        logic [ADDR_W-1:0] exp_first;
        stall_cycles = stall;
        rd_lat = lat;
        push_expected(s, e, p, sel, exp_cnt, exp_first);
        drive_start(s, e, p, sel);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1; start_addr = ~s; end_addr = ~e; pattern = ~p; pattern_sel = ~sel;
            repeat (2) @(posedge clk);
            #1;
            start = 1'b0;
            check("busy_during_poke", 32'(busy), 32'd1);
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("err_flag", 32'(err), 32'(exp_cnt != 0));
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt > 255 ? 255 : exp_cnt));
        check("err_addr", 32'(err_addr), 32'(exp_first));
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_count), 32'd1);
        check("err_cnt_hold", 32'(err_cnt), 32'(exp_cnt > 255 ? 255 : exp_cnt));
        check("err_addr_hold", 32'(err_addr), 32'(exp_first));
        sb.delete();
    endtask

    initial begin
        int dummy_cnt;
        logic [ADDR_W-1:0] dummy_first;
        amm.waitrequest   = 1'b0;
        amm.readdatavalid = 1'b0;
        amm.readdata      = '0;
        for (int i = 0; i < N; i++) begin
            zero_at[i] = 1'b0;
            mem[i]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        check("rst_req", 32'(amm.read | amm.write), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_no_req", 32'(amm.read | amm.write | busy), 32'd0);

        run_test(4'd2, 4'd5, 32'hA5A5A5A5, 1'b0, 0, 0, 1'b0);
        zero_at[2] = 1'b1;
        run_test(4'd0, 4'd3, 32'hFFFF0000, 1'b1, 0, 0, 1'b0);
        zero_at[2] = 1'b0;
        run_test(4'd5, 4'd9, 32'h12345678, 1'b1, 3, 2, 1'b0);
        run_test(4'd14, 4'd1, 32'h00000000, 1'b1, 0, 1, 1'b0);
        corrupt_all = 1'b1;
        run_test(4'd0, 4'd15, 32'h0F0F0F0F, 1'b1, 0, 0, 1'b0);
        corrupt_all = 1'b0;
        run_test(4'd7, 4'd7, 32'hDEADBEEF, 1'b0, 1, 0, 1'b0);
        run_test(4'd0, 4'd7, 32'hC3C3C3C3, 1'b1, 2, 1, 1'b1);

        // Reset while a read response is outstanding; the response lands after release.
        corrupt_all   = 1'b1;
        stall_cycles  = 0;
        rd_lat        = 6;
        read_accepted = 1'b0;
        push_expected(4'd3, 4'd4, 32'h55AA55AA, 1'b0, dummy_cnt, dummy_first);
        drive_start(4'd3, 4'd4, 32'h55AA55AA, 1'b0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (read_accepted) break;
        end
        check("rd_accepted", 32'(read_accepted), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'(amm.read | amm.write), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("late_rsp_sent", 32'(pending), 32'd0);
        check("late_rsp_busy", 32'(busy), 32'd0);
        check("late_rsp_err", 32'(err), 32'd0);
        check("late_rsp_cnt", 32'(err_cnt), 32'd0);
        corrupt_all = 1'b0;
        run_test(4'd10, 4'd12, 32'h0000FFFF, 1'b1, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
